// File: rtl/alu_pkg.sv
// Shared encodings for the alu and its request/response stage.
package alu_pkg;

  localparam logic [2:0] PASS_B = 3'b000;
  localparam logic [2:0] ADD    = 3'b010;
  localparam logic [2:0] SUB    = 3'b011;
  localparam logic [2:0] AND    = 3'b100;
  localparam logic [2:0] OR     = 3'b101;
  localparam logic [2:0] XOR    = 3'b110;

  // out_flags layout {N,Z,V,C}
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_C = 0;

  // architectural nzcv layout {N,Z,C,V}
  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_illegal(input logic [2:0] cntrol);
    return (cntrol == 3'b001) || (cntrol == 3'b111);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational alu: pass/add/sub/and/or/xor with N/Z/V/C flags.
// Subtraction is a + ~b + 1, so carry_out=1 means no borrow.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       cntrol,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             err
);

  logic             sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;

  assign sub  = (cntrol == SUB);
  assign b_op = sub ? ~b : b;
  assign sum  = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};

  always_comb begin
    result    = '0;
    overflow  = 1'b0;
    carry_out = 1'b0;
    err       = is_illegal(cntrol);
    case (cntrol)
      PASS_B: result = b;
      ADD, SUB: begin
        result    = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
        overflow  = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      AND:     result = a & b;
      OR:      result = a | b;
      XOR:     result = a ^ b;
      default: result = '0;
    endcase
  end

  assign negative = result[WIDTH-1];
  assign zero     = (result == '0) && !err;

endmodule

// File: rtl/alu_resp_stage.sv
// Registered valid/ready front-end around alu; keeps architectural NZCV.
// Optional ALU_RESP_OVF_CNT_EN adds a saturating overflow counter output.
module alu_resp_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_cntrol,
  input  logic             in_setf,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag,
`ifdef ALU_RESP_OVF_CNT_EN
  output logic [15:0]      ovf_cnt,
`endif
  output logic [3:0]       nzcv
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       cntrol;
    logic             setf;
    logic [TAG_W-1:0] tag;
  } req_t;

  state_t           state;
  req_t             req;
  logic [WIDTH-1:0] alu_result;
  logic             alu_n, alu_z, alu_v, alu_c, alu_err;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a        (req.a),
    .b        (req.b),
    .cntrol   (req.cntrol),
    .result   (alu_result),
    .negative (alu_n),
    .zero     (alu_z),
    .overflow (alu_v),
    .carry_out(alu_c),
    .err      (alu_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      req        <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      out_err    <= 1'b0;
      out_tag    <= '0;
      nzcv       <= '0;
`ifdef ALU_RESP_OVF_CNT_EN
      ovf_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            req      <= '{a: in_a, b: in_b, cntrol: in_cntrol, setf: in_setf, tag: in_tag};
            in_ready <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          // illegal codes report an all-zero result and flag vector
          out_result <= alu_err ? '0 : alu_result;
          out_flags  <= alu_err ? 4'b0 : {alu_n, alu_z, alu_v, alu_c};
          out_err    <= alu_err;
          out_tag    <= req.tag;
          out_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            if (req.setf && !out_err)
              nzcv <= {out_flags[FLG_N], out_flags[FLG_Z], out_flags[FLG_C], out_flags[FLG_V]};
`ifdef ALU_RESP_OVF_CNT_EN
            if (out_flags[FLG_V] && !out_err && ovf_cnt != 16'hFFFF)
              ovf_cnt <= ovf_cnt + 16'd1;
`endif
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_resp_stage.sv
// Directed table-driven bench for alu_resp_stage plus backpressure/reset sequences.
// Build with ALU_RESP_OVF_CNT_EN to also check the overflow counter.
module tb_alu_resp_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [63:0] in_a, in_b;
  logic [2:0]  in_cntrol;
  logic        in_setf;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic [3:0]  out_flags;
  logic        out_err;
  logic [3:0]  out_tag;
  logic [3:0]  nzcv;
`ifdef ALU_RESP_OVF_CNT_EN
  logic [15:0] ovf_cnt;
  logic [15:0] exp_ovf;
`endif

  int checks   = 0;
  int failures = 0;

  alu_resp_stage #(.WIDTH(64), .TAG_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cntrol (in_cntrol),
    .in_setf   (in_setf),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flags (out_flags),
    .out_err   (out_err),
    .out_tag   (out_tag),
`ifdef ALU_RESP_OVF_CNT_EN
    .ovf_cnt   (ovf_cnt),
`endif
    .nzcv      (nzcv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a, b;
    logic [2:0]  ctl;
    logic        setf;
    logic [3:0]  tag;
    logic [63:0] res;
    logic [3:0]  flags;   // {N,Z,V,C}
    logic        err;
    logic [3:0]  nzcv;    // {N,Z,C,V} after handshake
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    in_a = v.a; in_b = v.b; in_cntrol = v.ctl; in_setf = v.setf; in_tag = v.tag;
    in_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("exec_out_valid", {63'd0, out_valid}, 64'd0);
    chk("exec_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    chk("resp_out_valid", {63'd0, out_valid}, 64'd1);
    chk("resp_result", out_result, v.res);
    chk("resp_flags", {60'd0, out_flags}, {60'd0, v.flags});
    chk("resp_err", {63'd0, out_err}, {63'd0, v.err});
    chk("resp_tag", {60'd0, out_tag}, {60'd0, v.tag});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_out_valid", {63'd0, out_valid}, 64'd0);
    chk("post_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_nzcv", {60'd0, nzcv}, {60'd0, v.nzcv});
`ifdef ALU_RESP_OVF_CNT_EN
    if (v.flags[1] && !v.err) exp_ovf = exp_ovf + 16'd1;
    chk("ovf_cnt", {48'd0, ovf_cnt}, {48'd0, exp_ovf});
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    //        a                      b                      ctl     setf tag   res                    flags   err  nzcv
    vecs[0]  = '{64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, 3'b010, 1'b1, 4'h1, 64'hFFFFFFFFFFFFFFFE, 4'b1010, 1'b0, 4'b1001};
    vecs[1]  = '{64'h8000000000000000, 64'd12353,            3'b011, 1'b0, 4'h2, 64'h7FFFFFFFFFFFCFBF, 4'b0011, 1'b0, 4'b1001};
    vecs[2]  = '{64'd5,                64'd3,                3'b111, 1'b1, 4'h3, 64'd0,               4'b0000, 1'b1, 4'b1001};
    vecs[3]  = '{64'hDEADBEEF,         64'hDEADBEEF,         3'b110, 1'b1, 4'h4, 64'd0,               4'b0100, 1'b0, 4'b0100};
    vecs[4]  = '{64'd5,                64'd5,                3'b011, 1'b1, 4'h5, 64'd0,               4'b0101, 1'b0, 4'b0110};
    vecs[5]  = '{64'd1,                64'h8000000000000000, 3'b000, 1'b1, 4'h6, 64'h8000000000000000, 4'b1000, 1'b0, 4'b1000};
    vecs[6]  = '{64'hF0F0,             64'hFF00,             3'b100, 1'b0, 4'h7, 64'hF000,            4'b0000, 1'b0, 4'b1000};
    vecs[7]  = '{64'd0,                64'd0,                3'b101, 1'b1, 4'h8, 64'd0,               4'b0100, 1'b0, 4'b0100};
    vecs[8]  = '{64'd9,                64'd9,                3'b001, 1'b1, 4'h9, 64'd0,               4'b0000, 1'b1, 4'b0100};
    vecs[9]  = '{64'hFFFFFFFFFFFFFFFF, 64'd1,                3'b010, 1'b1, 4'hA, 64'd0,               4'b0101, 1'b0, 4'b0110};
    vecs[10] = '{64'd0,                64'd1,                3'b011, 1'b1, 4'hB, 64'hFFFFFFFFFFFFFFFF, 4'b1000, 1'b0, 4'b1000};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cntrol = '0; in_setf = 1'b0; in_tag = '0;
`ifdef ALU_RESP_OVF_CNT_EN
    exp_ovf = 16'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_nzcv", {60'd0, nzcv}, 64'd0);
    chk("rst_result", out_result, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // backpressure: ADD 3+4 held 5 cycles while a second request waits
    @(negedge clk);
    in_a = 64'd3; in_b = 64'd4; in_cntrol = 3'b010; in_setf = 1'b0; in_tag = 4'hC;
    in_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    in_a = 64'hFF; in_b = 64'h0F; in_cntrol = 3'b100; in_setf = 1'b0; in_tag = 4'hD;
    @(posedge clk); #1;
    chk("bp_valid", {63'd0, out_valid}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_result", out_result, 64'd7);
      chk("bp_hold_tag", {60'd0, out_tag}, 64'hC);
      chk("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_rel_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp2_exec_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk("bp2_valid", {63'd0, out_valid}, 64'd1);
    chk("bp2_result", out_result, 64'h0F);
    chk("bp2_tag", {60'd0, out_tag}, 64'hD);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp2_nzcv", {60'd0, nzcv}, 64'b1000);

    // reset in the middle of EXEC discards the op
    @(negedge clk);
    in_a = 64'd1; in_b = 64'd1; in_cntrol = 3'b010; in_setf = 1'b1; in_tag = 4'h3;
    in_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_nzcv", {60'd0, nzcv}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
`ifdef ALU_RESP_OVF_CNT_EN
    chk("mid_rst_ovf_cnt", {48'd0, ovf_cnt}, 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk("post_rst_no_resp", {63'd0, out_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_resp_stage.md
Name: alu_resp_stage

Overview:
Registered request/response front-end around the existing 64-bit combinational alu. It accepts operations from an issuing master over a valid/ready handshake and holds them in operand registers. It captures result and flags one cycle later and returns them over a second valid/ready channel. It also keeps the architectural NZCV flag register for flag-setting operations, so it is the consumer end of the alu result/flag interface.

Parameters:
WIDTH, 64, operand/result width; must match the alu instance.
TAG_W, 4, width of the opaque request tag echoed in the response.

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cntrol  input  3  alu control code
in_setf  input  1  update NZCV when this response is accepted
in_tag  input  TAG_W  request tag
out_valid  output  1  response valid
out_ready  input  1  consumer accepts response
out_result  output  WIDTH  alu result
out_flags  output  4  {negative, zero, overflow, carry_out} of this op
out_err  output  1  illegal cntrol code (001 or 111)
out_tag  output  TAG_W  echoed tag
nzcv  output  4  architectural flag register {N,Z,C,V}

Behaviour:
- Reset (async, reset_n=0): state=IDLE; in_ready=0 while reset is asserted; out_valid=0; out_result=0; out_flags=0; out_err=0; out_tag=0; nzcv=0; operand regs=0.
- The reset clears any in-flight op mid-operation. No response is produced for it.
- FSM IDLE -> EXEC -> RESP -> IDLE.
- IDLE: in_ready=1. On in_valid&in_ready at edge t, latch a/b/cntrol/setf/tag and go to EXEC.
- EXEC: in_ready=0. The alu is driven from the operand regs. At edge t+1, register result, flags and err (cntrol in {001,111}), then go to RESP. out_valid is high after edge t+1, so latency is 1 cycle from accept to valid.
- RESP: out_valid=1. Outputs are held stable until out_valid&out_ready.
- On the accepting edge:
  - If setf=1 and err=0, nzcv <= {negative, zero, carry_out, overflow}.
  - Then go to IDLE.
- Illegal code: result=0, flags=0, err=1, nzcv unchanged.
- No new request is accepted in EXEC or RESP, so in_valid is ignored there. Throughput is 1 op per 3 cycles when out_ready is held high.
- out_ready asserted before out_valid has no effect.

Optional Feature:
- Macro: ALU_RESP_OVF_CNT_EN.
- When defined: adds output ovf_cnt [15:0]. It increments on each accepted response whose overflow flag=1 and err=0, and saturates at 16'hFFFF. It resets to 0.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header alu_pkg holds:
  - cntrol encodings: PASS_B=000, ADD=010, SUB=011, AND=100, OR=101, XOR=110.
  - Flag bit index constants.
  - FSM state encodings IDLE/EXEC/RESP.
- Single sub-module: the existing alu, instantiated unchanged. No other hierarchy.

Test Plan:
- Reset: assert reset_n=0 mid-EXEC -> out_valid=0 and nzcv=0 immediately; in_ready=1 one cycle after release.
- ADD with setf=1: a=64'h7FFFFFFFFFFFFFFF, b=64'h7FFFFFFFFFFFFFFF -> out_result=64'hFFFFFFFFFFFFFFFE, negative=1, overflow=1, carry_out=0; out_valid one cycle after accept; nzcv=4'b1001 after out handshake.
- SUB with setf=0: a=64'h8000000000000000, b=64'd12353 -> overflow=1, result=64'h7FFFFFFFFFFFCFBF; nzcv unchanged.
- Backpressure: out_ready=0 for 5 cycles -> result/tag stable, in_ready=0, a second in_valid is not accepted; release -> back-to-back op completes.
- Illegal code: cntrol=3'b111, setf=1 -> out_err=1, result=0, nzcv unchanged.
- XOR a=b=64'hDEADBEEF -> result=0, zero=1; with ALU_RESP_OVF_CNT_EN, ovf_cnt is unchanged by this op and increments by exactly 1 after the ADD overflow case.
